dmem_router: RTL
================

// Module: dmem_router
// PURPOSE
//  Parametrised data-bus address router between the core's dmem port and NSLV slaves (RAM, CLINT, peripherals).
//  Decodes addr[SEL_HI:SEL_LO] against per-slave base codes on both write and read channels.
//  Tracks accepted reads in an RLAT-deep pipeline so returned data/resp come from the correct slave.
//  Flags unmapped accesses as decode errors.
// PARAMETERS
//  NSLV        2             number of slaves, 1..8
//  SEL_HI      31            MSB of address decode field
//  SEL_LO      28            LSB of decode field; SW = SEL_HI-SEL_LO+1
//  BASE        {4'hC,4'h0}   packed NSLV*SW codes; slave i = BASE[i*SW +: SW]
//  DEFAULT_SLV NSLV          slave taking unmatched addresses; NSLV = none (decode error)
//  RLAT        1             read data latency after accept, 1..4 cycles
// PORTS
//  clk        in   1         clock
//  reset      in   1         reset; asynchronous, active-high
//  m_wready   in   1         core write request
//  m_wvalid   out  1         write accepted
//  m_waddr    in   32        write address
//  m_wdata    in   32        write data
//  m_wstrb    in   4         byte strobes
//  m_rready   in   1         core read request
//  m_rvalid   out  1         read accepted
//  m_raddr    in   32        read address
//  m_rresp    out  1         1 = OK, 0 = error; valid RLAT cycles after accept
//  m_rdata    out  32        read data; valid RLAT cycles after accept
//  s_wready   out  NSLV      per-slave write request
//  s_wvalid   in   NSLV      per-slave write accept
//  s_waddr    out  32        shared: m_waddr
//  s_wdata    out  32        shared: m_wdata
//  s_wstrb    out  4         shared: m_wstrb
//  s_rready   out  NSLV      per-slave read request
//  s_rvalid   in   NSLV      per-slave read accept
//  s_raddr    out  32        shared: m_raddr
//  s_rresp    in   NSLV      per-slave response status
//  s_rdata    in   NSLV*32   per-slave read data, slave i at [i*32 +: 32]
//  dec_err    out  1         one-cycle pulse per accepted unmapped access
// BEHAVIOUR
//  - Decode: combinational; lowest index wins on multiple matches; else DEFAULT_SLV; else error.
//  - Requests and accepts: s_wready[i] = m_wready & hit_w[i]; m_wvalid = |(s_wvalid & hit_w).
//    Read side is the same with s_rready, s_rvalid and hit_r.
//  - Unmapped request: no s_*ready asserted; m_*valid = 1 in the same cycle, so the core never hangs.
//  - Read tracking: on accept (m_rready & m_rvalid) push {1, err, idx} into RLAT-stage shift register.
//    Stage RLAT-1 selects m_rdata = s_rdata[idx] and m_rresp = s_rresp[idx].
//    When err is set: m_rdata = 0, m_rresp = 0.
//  - One read accepted per cycle; back-to-back reads to different slaves return in order, one per cycle.
//  - No read in the output stage: m_rdata = 0, m_rresp = 1.
//  - Simultaneous read and write: independent channels, no arbitration.
//  - dec_err: registered; asserted the cycle after an accepted unmapped read or write.
//    Asserted once if both channels are unmapped in the same cycle.
//  - Reset (any time, including mid-read): pipeline valids, dec_err and counter cleared.
//    Outputs forced m_rdata = 0, m_rresp = 1; in-flight responses dropped.
//  - m_wvalid, m_rvalid and s_*ready are combinational and follow inputs during reset.
// CONFIGURATION
//  DMEM_ROUTER_ERR_CNT_EN defined:
//    Adds output err_cnt [15:0], a saturating count of dec_err pulses.
//    Holds at 16'hFFFF; cleared by reset.
//  DMEM_ROUTER_ERR_CNT_EN not defined: port and counter absent; dec_err still present.
// TESTING
//  - NSLV=2, RLAT=1: read 0x0000_0010 (s_rdata0=0x11) then 0xC000_0004 (s_rdata1=0x22) back-to-back.
//    Expect m_rdata 0x11 then 0x22 on consecutive cycles, m_rresp=1.
//  - Write 0xC000_0000, strb 4'hF, slave1 s_wvalid=1.
//    Expect only s_wready[1]=1, s_wdata passthrough, m_wvalid=1 same cycle.
//  - DEFAULT_SLV=NSLV: read 0x5000_0000.
//    Expect m_rvalid=1 same cycle, no s_rready, then m_rdata=0, m_rresp=0, dec_err=1.
//  - RLAT=3: accept read to slave0, slave0 withholds s_rvalid 2 cycles.
//    Expect m_rvalid low 2 cycles, data returned exactly 3 cycles after the accept.
//  - Assert reset with 2 reads in flight (RLAT=3).
//    Expect m_rresp=1, m_rdata=0 immediately; no stale data after release.
//  - ERR_CNT_EN: 3 unmapped writes then reset. Expect err_cnt=3, then 0.

Source files
------------

// File: rtl/dmem_router_if.sv
// dmem_router_if - core-side and slave-side data bus bundle for dmem_router
//
// Purpose: carries the core dmem port (m_*) and the fan-out to NSLV slaves (s_*).
// Note the polarity of names on this bus: *ready is the request, *valid is the accept.
// Modports:
//   slave  - router view: takes core requests, answers the core, drives slave requests
//   master - environment view (core + slaves): complement of slave
// Signals:
//   m_wready/m_waddr/m_wdata/m_wstrb  core write request, m_wvalid write accept
//   m_rready/m_raddr                  core read request, m_rvalid read accept
//   m_rresp/m_rdata                   read response, RLAT cycles after accept
//   s_wready/s_rready [NSLV]          per-slave requests, s_wvalid/s_rvalid accepts
//   s_waddr/s_wdata/s_wstrb/s_raddr   shared copies of the core request fields
//   s_rresp [NSLV], s_rdata [NSLV*32] per-slave response status and data
interface dmem_router_if #(
  parameter int NSLV = 2
);
  logic                 m_wready;
  logic                 m_wvalid;
  logic [31:0]          m_waddr;
  logic [31:0]          m_wdata;
  logic [3:0]           m_wstrb;
  logic                 m_rready;
  logic                 m_rvalid;
  logic [31:0]          m_raddr;
  logic                 m_rresp;
  logic [31:0]          m_rdata;
  logic [NSLV-1:0]      s_wready;
  logic [NSLV-1:0]      s_wvalid;
  logic [31:0]          s_waddr;
  logic [31:0]          s_wdata;
  logic [3:0]           s_wstrb;
  logic [NSLV-1:0]      s_rready;
  logic [NSLV-1:0]      s_rvalid;
  logic [31:0]          s_raddr;
  logic [NSLV-1:0]      s_rresp;
  logic [NSLV*32-1:0]   s_rdata;

  modport slave (
    input  m_wready, m_waddr, m_wdata, m_wstrb, m_rready, m_raddr,
    output m_wvalid, m_rvalid, m_rresp, m_rdata,
    output s_wready, s_waddr, s_wdata, s_wstrb, s_rready, s_raddr,
    input  s_wvalid, s_rvalid, s_rresp, s_rdata
  );

  modport master (
    output m_wready, m_waddr, m_wdata, m_wstrb, m_rready, m_raddr,
    input  m_wvalid, m_rvalid, m_rresp, m_rdata,
    input  s_wready, s_waddr, s_wdata, s_wstrb, s_rready, s_raddr,
    output s_wvalid, s_rvalid, s_rresp, s_rdata
  );
endinterface

// File: rtl/dmem_router.sv
// dmem_router - address-decoding data bus router from the core dmem port to NSLV slaves
//
// Purpose: decodes addr[SEL_HI:SEL_LO] against per-slave BASE codes on the write and read
// channels, forwards requests to the matching slave, tracks accepted reads through an
// RLAT-deep pipeline so the response is taken from the right slave, and flags unmapped
// accesses on dec_err.
// Optional feature: DMEM_ROUTER_ERR_CNT_EN adds err_cnt, a saturating count of dec_err pulses.
// Ports:
//   clk      clock
//   reset    asynchronous active-high reset
//   bus      dmem_router_if.slave (core side m_*, slave side s_*)
//   dec_err  one-cycle pulse the cycle after an accepted unmapped read and/or write
//   err_cnt  [15:0] saturating dec_err count (only with DMEM_ROUTER_ERR_CNT_EN)
module dmem_router #(
  parameter int NSLV = 2,
  parameter int SEL_HI = 31,
  parameter int SEL_LO = 28,
  parameter logic [NSLV*(SEL_HI-SEL_LO+1)-1:0] BASE = {4'hC, 4'h0},
  parameter int DEFAULT_SLV = NSLV,
  parameter int RLAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  dmem_router_if.slave  bus,
  output logic          dec_err
`ifdef DMEM_ROUTER_ERR_CNT_EN
  ,
  output logic [15:0]   err_cnt
`endif
);
  localparam int SW = SEL_HI - SEL_LO + 1;
  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  // One-hot hit vector; descending scan lets the lowest matching index win.
  // An empty result after the fallback means the access is unmapped.
  function automatic logic [NSLV-1:0] decode(input logic [SW-1:0] sel);
    logic [NSLV-1:0] h;
    h = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (sel == BASE[i*SW +: SW]) begin
        h    = '0;
        h[i] = 1'b1;
      end
    end
    if (h == '0) begin
      for (int i = 0; i < NSLV; i++) begin
        if (i == DEFAULT_SLV) h[i] = 1'b1;
      end
    end
    return h;
  endfunction

  function automatic logic [IW-1:0] to_idx(input logic [NSLV-1:0] h);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (h[i]) r = IW'(i);
    end
    return r;
  endfunction

  logic [NSLV-1:0] hit_w, hit_r;
  logic            w_err, r_err, r_acc;

  assign hit_w = decode(bus.m_waddr[SEL_HI:SEL_LO]);
  assign hit_r = decode(bus.m_raddr[SEL_HI:SEL_LO]);
  assign w_err = ~|hit_w;
  assign r_err = ~|hit_r;

  assign bus.s_waddr  = bus.m_waddr;
  assign bus.s_wdata  = bus.m_wdata;
  assign bus.s_wstrb  = bus.m_wstrb;
  assign bus.s_raddr  = bus.m_raddr;
  assign bus.s_wready = {NSLV{bus.m_wready}} & hit_w;
  assign bus.s_rready = {NSLV{bus.m_rready}} & hit_r;
  // Unmapped requests are accepted immediately so the core never stalls on them.
  assign bus.m_wvalid = w_err | (|(bus.s_wvalid & hit_w));
  assign bus.m_rvalid = r_err | (|(bus.s_rvalid & hit_r));
  assign r_acc        = bus.m_rready & bus.m_rvalid;

  // Read tracking pipeline: stage 0 captures the accept, stage RLAT-1 drives the response.
  logic [RLAT-1:0] pv;
  logic [RLAT-1:0] pe;
  logic [IW-1:0]   pidx [RLAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv      <= '0;
      pe      <= '0;
      dec_err <= 1'b0;
      for (int k = 0; k < RLAT; k++) pidx[k] <= '0;
    end else begin
      pv[0]   <= r_acc;
      pe[0]   <= r_err;
      pidx[0] <= to_idx(hit_r);
      for (int k = 1; k < RLAT; k++) begin
        pv[k]   <= pv[k-1];
        pe[k]   <= pe[k-1];
        pidx[k] <= pidx[k-1];
      end
      // An unmapped request is always accepted, so request implies accept here.
      dec_err <= (bus.m_wready & w_err) | (bus.m_rready & r_err);
    end
  end

  logic [IW-1:0] oidx;
  assign oidx = pidx[RLAT-1];

  always_comb begin
    bus.m_rdata = '0;
    bus.m_rresp = 1'b1;
    if (pv[RLAT-1]) begin
      if (pe[RLAT-1]) begin
        bus.m_rresp = 1'b0;
      end else begin
        bus.m_rdata = bus.s_rdata[32*oidx +: 32];
        bus.m_rresp = bus.s_rresp[oidx];
      end
    end
  end

`ifdef DMEM_ROUTER_ERR_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (dec_err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif
endmodule
